// File: rtl/synth_pkg.sv
// Shared types and defaults for the note sequencer slice.
package synth_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } seq_state_t;

    localparam int DEFAULT_MIN_GAP   = 2048;
    localparam int DEFAULT_FREQ_BITS = 4;

    // Slot layout as seen on the write bus at the default tone width.
    typedef struct packed {
        logic                         tie;
        logic                         gate_en;
        logic [DEFAULT_FREQ_BITS-1:0] freq_bin;
    } seq_slot_t;

endpackage

// File: rtl/note_sequencer_if.sv
// Slot-programming bus into the note sequencer.
interface note_sequencer_if #(
    parameter int STEPS     = 8,
    parameter int FREQ_BITS = 4
) ();
    localparam int AW = $clog2(STEPS);

    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [FREQ_BITS+1:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/seq_step_ram.sv
// Step slot register file: synchronous clear, one write port, one combinational read port.
module seq_step_ram #(
    parameter int STEPS     = 8,
    parameter int SLOT_BITS = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(STEPS)-1:0] wr_addr,
    input  logic [SLOT_BITS-1:0]     wr_data,
    input  logic [$clog2(STEPS)-1:0] rd_addr,
    output logic [SLOT_BITS-1:0]     rd_data
);
    logic [SLOT_BITS-1:0] mem_r [STEPS];

    // Slot storage: cleared on reset, one slot written per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/note_sequencer.sv
// Looping step sequencer feeding tone_freq_bin and hold (gate) into soundproc.
// Optional legato ties are enabled by defining SEQ_TIE_EN.
module note_sequencer
    import synth_pkg::*;
#(
    parameter int STEPS     = 8,
    parameter int FREQ_BITS = 4,
    parameter int TIME_BITS = 16,
    parameter int MIN_GAP   = DEFAULT_MIN_GAP
) (
    input  logic                     clk,
    input  logic                     rst_n,
    note_sequencer_if.slave          wr_bus,
    input  logic                     run,
    input  logic [$clog2(STEPS)-1:0] last_step,
    input  logic [TIME_BITS-1:0]     step_period,
    input  logic [TIME_BITS-1:0]     gate_len,
    output logic [FREQ_BITS-1:0]     tone_freq_bin,
    output logic                     gate,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     step_strobe,
    output logic                     busy
);
    localparam int AW = $clog2(STEPS);
`ifdef SEQ_TIE_EN
    localparam int SLOT_BITS = FREQ_BITS + 2;
`else
    localparam int SLOT_BITS = FREQ_BITS + 1;
`endif
    localparam logic [TIME_BITS-1:0] MIN_GAP_T = TIME_BITS'(MIN_GAP);

    seq_state_t           state_r, state_s;
    logic [TIME_BITS-1:0] counter_r, counter_s;
    logic [TIME_BITS-1:0] eff_period_s, period_m1_s, gap_limit_s;
    logic [AW-1:0]        succ_idx_s, rd_addr_s, step_idx_s;
    logic [SLOT_BITS-1:0] wr_slot_s, rd_data_s;
    logic [FREQ_BITS-1:0] tone_s;
    logic                 gate_en_r, gate_en_s;
    logic                 load_s, gate_s, strobe_s, busy_s;
`ifdef SEQ_TIE_EN
    logic                 tie_r, tie_s;

    assign wr_slot_s = wr_bus.wr_data;
`else
    logic                 tie_unused_s;

    assign wr_slot_s    = wr_bus.wr_data[FREQ_BITS:0];
    assign tie_unused_s = wr_bus.wr_data[FREQ_BITS+1];
`endif

    // The read port always looks at the slot that would be loaded next.
    assign eff_period_s = (step_period == '0) ? TIME_BITS'(1) : step_period;
    assign period_m1_s  = eff_period_s - TIME_BITS'(1);
    assign gap_limit_s  = (eff_period_s > MIN_GAP_T) ? (eff_period_s - MIN_GAP_T) : '0;
    assign succ_idx_s   = (step_idx >= last_step) ? '0 : (step_idx + AW'(1));
    assign rd_addr_s    = (state_r == PLAY) ? succ_idx_s : '0;

    seq_step_ram #(
        .STEPS     (STEPS),
        .SLOT_BITS (SLOT_BITS)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_bus.wr_en),
        .wr_addr (wr_bus.wr_addr),
        .wr_data (wr_slot_s),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    // Next-state, step advance and next output values.
    always_comb begin
        state_s    = state_r;
        counter_s  = counter_r;
        step_idx_s = step_idx;
        tone_s     = tone_freq_bin;
        gate_en_s  = gate_en_r;
        load_s     = 1'b0;
        strobe_s   = 1'b0;
        gate_s     = 1'b0;
`ifdef SEQ_TIE_EN
        tie_s      = tie_r;
`endif
        case (state_r)
            IDLE: begin
                counter_s  = '0;
                step_idx_s = '0;
                if (run) begin
                    state_s = PLAY;
                    load_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            PLAY: begin
                if (!run) begin
                    state_s    = IDLE;
                    counter_s  = '0;
                    step_idx_s = '0;
                end else if (counter_r == period_m1_s) begin
                    counter_s  = '0;
                    step_idx_s = succ_idx_s;
                    load_s     = 1'b1;
                end else begin
                    counter_s  = counter_r + TIME_BITS'(1);
                end
            end
            default: begin
                state_s    = IDLE;
                counter_s  = '0;
                step_idx_s = '0;
            end
        endcase

        if (load_s) begin
            tone_s    = rd_data_s[FREQ_BITS-1:0];
            gate_en_s = rd_data_s[FREQ_BITS];
            strobe_s  = 1'b1;
`ifdef SEQ_TIE_EN
            tie_s     = rd_data_s[FREQ_BITS+1];
`endif
        end else begin
            strobe_s  = 1'b0;
        end

        busy_s = (state_s == PLAY);
        if (busy_s) begin
            gate_s = gate_en_s && (counter_s < gate_len) && (counter_s < gap_limit_s);
`ifdef SEQ_TIE_EN
            // A tie into a gated slot holds the gate through the gap (legato).
            if (!load_s && tie_s && rd_data_s[FREQ_BITS]) begin
                gate_s = gate_en_s;
            end else begin
                gate_s = gate_s;
            end
`endif
        end else begin
            gate_s = 1'b0;
        end
    end

    // State, counter, latched step data and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            counter_r     <= '0;
            gate_en_r     <= 1'b0;
            tone_freq_bin <= '0;
            gate          <= 1'b0;
            step_idx      <= '0;
            step_strobe   <= 1'b0;
            busy          <= 1'b0;
`ifdef SEQ_TIE_EN
            tie_r         <= 1'b0;
`endif
        end else begin
            state_r       <= state_s;
            counter_r     <= counter_s;
            gate_en_r     <= gate_en_s;
            tone_freq_bin <= tone_s;
            gate          <= gate_s;
            step_idx      <= step_idx_s;
            step_strobe   <= strobe_s;
            busy          <= busy_s;
`ifdef SEQ_TIE_EN
            tie_r         <= tie_s;
`endif
        end
    end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Step sequencer directly upstream of soundproc, in the main clk domain.
- Stores up to STEPS programmable notes and replays them in a loop at a programmable step period.
- Drives tone_freq_bin and hold (gate) into soundproc.
- Guarantees a gate-low gap before every retrigger, so the envelope's hold rising-edge detector fires each step.

Parameters:
STEPS, 8, number of step slots (power of 2)
FREQ_BITS, 4, width of per-step tone_freq_bin
TIME_BITS, 16, width of step_period / gate_len counters
MIN_GAP, 2048, minimum gate-low cycles at end of each step (≥ one sample_clk period at main clk)

Ports:
clk  in  1  main clock
rst_n  in  1  synchronous, active-low reset
wr_en  in  1  write one step slot this cycle
wr_addr  in  $clog2(STEPS)  slot index
wr_data  in  FREQ_BITS+2  {tie, gate_en, freq_bin}; tie used only with SEQ_TIE_EN
run  in  1  level: 1 = play, 0 = stop
last_step  in  $clog2(STEPS)  loop end index (loop is 0..last_step)
step_period  in  TIME_BITS  clk cycles per step
gate_len  in  TIME_BITS  requested gate-high cycles per step
tone_freq_bin  out  FREQ_BITS  to soundproc tone_freq_bin
gate  out  1  to soundproc hold
step_idx  out  $clog2(STEPS)  currently playing slot
step_strobe  out  1  one-cycle pulse when a step is loaded
busy  out  1  high in PLAY

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-low on rst_n. All outputs are registered.
- Reset values:
  - tone_freq_bin=0, gate=0, step_idx=0, step_strobe=0, busy=0.
  - All slots cleared to 0; state IDLE; counter 0.
- State IDLE (gate=0, busy=0):
  - run sampled high → PLAY next cycle with step_idx=0, counter=0, slot 0 latched into tone_freq_bin, step_strobe=1.
  - Latency is 1 cycle from run high to outputs valid.
- State PLAY (busy=1):
  - counter increments each cycle.
  - When counter == step_period-1: counter←0; step_idx←(step_idx≥last_step)?0:step_idx+1; new slot latched; step_strobe=1.
  - Effective step_period = max(step_period, 1).
- Gate in PLAY: gate = gate_en(latched) && counter < gate_len && counter < step_period-MIN_GAP. All comparisons are unsigned.
  - If step_period ≤ MIN_GAP, gate stays 0 for the whole step.
  - gate_len=0 gives gate 0.
- Step data is latched only at step load. A write to the playing slot takes effect the next time that slot is loaded.
- Writes are accepted in any state. Simultaneous write and load of the same slot: the loaded value is the OLD content; the write lands.
- last_step changed mid-loop: it is checked only at step advance. If step_idx > new last_step, the next step is 0.
- run sampled low in PLAY:
  - Next cycle IDLE, gate=0, step_idx=0, step_strobe=0.
  - tone_freq_bin holds its last value, so the release tail keeps its pitch.
- run high again: restarts from slot 0.
- rst_n low mid-play: full reset next edge; it has priority over run and wr_en.

Optional Feature:
- Macro SEQ_TIE_EN.
- Defined: slot tie bit is stored. When the current slot has tie=1 and the next slot has gate_en=1, gate stays high through the MIN_GAP window and across the boundary (legato, no envelope retrigger). Pitch still changes at the boundary. gate_len limits still apply to untied steps.
- Undefined: tie bit is not stored (slots are FREQ_BITS+1 wide); behaviour is exactly as above.

Decomposition:
- Package synth_pkg:
  - seq_state_t enum {IDLE, PLAY}.
  - seq_slot_t packed struct {tie, gate_en, freq_bin}.
  - Default MIN_GAP constant.
- One sub-module, seq_step_ram: STEPS-entry register file with a synchronous-reset clear, one write port and one combinational read port addressed by the next step index.
- The sequencer FSM, counter and gate comparator live in note_sequencer.

Test Plan:
- Bench parameters: MIN_GAP=2, step_period=8, gate_len=4, last_step=2.
- Reset: all outputs 0. Read back via play shows every slot freq_bin=0, gate_en=0 → gate never high.
- Program slots 0/1/2 = freq 3/5/9, gate_en=1; run=1 → step_strobe every 8 cycles; tone_freq_bin sequence 3,5,9,3; gate high cycles 0-3 of each step; step_idx wraps 2→0.
- gate_len=20, step_period=8 → gate high cycles 0-5, low cycles 6-7 of each step. step_period=2 → gate never high.
- Write slot 1=freq 12 while slot 1 is playing → current step keeps 5; next pass shows 12.
- Drop run at counter=3 of slot 1 → next cycle gate=0, busy=0, step_idx=0, tone_freq_bin=5 held. run=1 → restarts at slot 0 (freq 3).
- SEQ_TIE_EN defined: slot 0 tie=1 → with gate_len=20, gate stays high continuously from slot 0 into slot 1 with no low cycle at that boundary; the gap appears at the 1→2 boundary.
